// File: rtl/cache_request_arbiter.sv
// Round-robin arbiter sharing one cache request port among N requesters.
// Ports: req_* per-requester handshake in, cache_req_* registered request
// out, cache_resp_* in, resp_* one-hot routed response out, plus credit
// count, idle and sticky error status.
module cache_request_arbiter #(
  parameter int NUM_MEMORY_REQUESTOR    = 4,
  parameter int REQ_WIDTH               = 644,
  parameter int RESP_WIDTH              = 512,
  parameter int OUTSTANDING_COUNTER_MAX = 16,
  parameter int ID_WIDTH = $clog2(NUM_MEMORY_REQUESTOR)
) (
  input  logic ap_clk,
  input  logic areset,
  input  logic enable_in,
  input  logic [NUM_MEMORY_REQUESTOR-1:0] req_valid_in,
  input  logic [NUM_MEMORY_REQUESTOR*REQ_WIDTH-1:0] req_payload_in,
  output logic [NUM_MEMORY_REQUESTOR-1:0] req_ready_out,
  output logic cache_req_valid_out,
  output logic [REQ_WIDTH-1:0] cache_req_payload_out,
  input  logic cache_req_ready_in,
  input  logic cache_resp_valid_in,
  input  logic [RESP_WIDTH-1:0] cache_resp_payload_in,
  output logic [NUM_MEMORY_REQUESTOR-1:0] resp_valid_out,
  output logic [RESP_WIDTH-1:0] resp_payload_out,
  output logic [$clog2(OUTSTANDING_COUNTER_MAX+1)-1:0] outstanding_count_out,
  output logic idle_out,
  output logic resp_error_out
);

  localparam int N   = NUM_MEMORY_REQUESTOR;
  localparam int MAX = OUTSTANDING_COUNTER_MAX;
  localparam int CW  = $clog2(MAX + 1);
  localparam int PW  = (MAX > 1) ? $clog2(MAX) : 1;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_IDLE,
    ST_ACTIVE
  } state_e;

  state_e state_q, state_d;
  logic idle_q, idle_d;
  logic [ID_WIDTH-1:0] rr_q, rr_d;
  logic cvalid_q, cvalid_d;
  logic [REQ_WIDTH-1:0] cpay_q, cpay_d;
  logic [N-1:0] rvalid_q, rvalid_d;
  logic [RESP_WIDTH-1:0] rpay_q, rpay_d;
  logic [CW-1:0] count_q, count_d;
  logic err_q, err_d;
  logic [ID_WIDTH-1:0] fifo_q [MAX];
  logic [ID_WIDTH-1:0] fifo_d [MAX];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;

  logic out_free;
  logic can_grant;
  logic grant;
  logic pop;
  logic [N-1:0] hi_mask;
  logic [N-1:0] hi_req;
  logic [N-1:0] pick_src;
  logic [ID_WIDTH-1:0] gnt_idx;
  logic [N-1:0] gnt_oh;
  logic [REQ_WIDTH-1:0] gnt_pay;

  // Credit uses only the registered count so that no path exists
  // from cache_resp_* into req_ready_out.
  assign out_free  = !cvalid_q || cache_req_ready_in;
  assign can_grant = enable_in && (state_q != ST_RESET) &&
                     (count_q < CW'(MAX)) && out_free;
  assign grant     = can_grant && (|req_valid_in);
  assign pop       = cache_resp_valid_in && (count_q != '0);

  // Prefer requesters at or above the pointer; wrap to the
  // lowest valid one otherwise.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < N; i++) begin
      hi_mask[i] = (ID_WIDTH'(i) >= rr_q);
    end
    hi_req   = req_valid_in & hi_mask;
    pick_src = (|hi_req) ? hi_req : req_valid_in;
    gnt_idx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pick_src[i]) gnt_idx = ID_WIDTH'(i);
    end
  end

  always_comb begin
    gnt_oh  = '0;
    gnt_pay = '0;
    for (int i = 0; i < N; i++) begin
      gnt_oh[i] = grant && (gnt_idx == ID_WIDTH'(i));
      if (gnt_oh[i]) begin
        gnt_pay = req_payload_in[i*REQ_WIDTH +: REQ_WIDTH];
      end
    end
  end

  assign req_ready_out = gnt_oh;

  always_comb begin
    rr_d     = rr_q;
    cvalid_d = cvalid_q;
    cpay_d   = cpay_q;
    fifo_d   = fifo_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    rvalid_d = '0;
    rpay_d   = rpay_q;
    err_d    = err_q;
    count_d  = count_q;

    if (grant) begin
      cvalid_d     = 1'b1;
      cpay_d       = gnt_pay;
      fifo_d[wr_q] = gnt_idx;
      wr_d = (wr_q == PW'(MAX - 1)) ? '0 : wr_q + PW'(1);
      rr_d = (gnt_idx == ID_WIDTH'(N - 1)) ? '0
             : gnt_idx + ID_WIDTH'(1);
    end else if (cvalid_q && cache_req_ready_in) begin
      cvalid_d = 1'b0;
    end

    if (pop) begin
      rvalid_d[fifo_q[rd_q]] = 1'b1;
      rpay_d = cache_resp_payload_in;
      rd_d = (rd_q == PW'(MAX - 1)) ? '0 : rd_q + PW'(1);
    end else if (cache_resp_valid_in) begin
      // Response with nothing in flight is dropped.
      err_d = 1'b1;
    end

    unique case ({grant, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET: state_d = ST_IDLE;
      ST_IDLE: begin
        if (grant) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!cvalid_q && (count_q == '0) && !grant) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_RESET;
    endcase
    idle_d = (state_q == ST_IDLE);
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      state_q  <= ST_RESET;
      idle_q   <= 1'b0;
      rr_q     <= '0;
      cvalid_q <= 1'b0;
      cpay_q   <= '0;
      rvalid_q <= '0;
      rpay_q   <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      for (int i = 0; i < MAX; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idle_q   <= idle_d;
      rr_q     <= rr_d;
      cvalid_q <= cvalid_d;
      cpay_q   <= cpay_d;
      rvalid_q <= rvalid_d;
      rpay_q   <= rpay_d;
      count_q  <= count_d;
      err_q    <= err_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      fifo_q   <= fifo_d;
    end
  end

  assign cache_req_valid_out   = cvalid_q;
  assign cache_req_payload_out = cpay_q;
  assign resp_valid_out        = rvalid_q;
  assign resp_payload_out      = rpay_q;
  assign outstanding_count_out = count_q;
  assign idle_out              = idle_q;
  assign resp_error_out        = err_q;

endmodule
